// File: rtl/rr_bin_arb.sv
// rr_bin_arb: round-robin arbiter. It returns the winning requester as a binary index and
// uses a valid/ready handshake on the output side.
//
// The grant is registered. Once vld is asserted, the grant holds until it is accepted
// (vld && rdy). Each acceptance moves the priority pointer to the index just after the
// accepted one. The search for the next winner runs in the same cycle as the acceptance,
// so grants can issue back-to-back.
//
// Ports:
//   clk  - clock; all state updates on the rising edge
//   rst  - synchronous active-high reset
//   req  - request vector, bit i = requester i
//   vld  - grant valid (registered)
//   rdy  - downstream ready; grant accepted when vld && rdy
//   bin  - granted requester index (registered; keeps its last value while vld=0)
//   ptr  - current priority pointer, for debug/observability
module rr_bin_arb #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     req,
   output logic                 vld,
   input  logic                 rdy,
   output logic [WIDTH_LOG-1:0] bin,
   output logic [WIDTH_LOG-1:0] ptr
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   localparam logic [WIDTH_LOG-1:0] LastIdx = WIDTH_LOG'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [WIDTH_LOG-1:0] bin_q, bin_d;
   logic [WIDTH_LOG-1:0] ptr_q, ptr_d;

   logic                 accept;
   logic [WIDTH_LOG-1:0] bin_inc;
   logic [WIDTH_LOG-1:0] search_base;
   logic [WIDTH-1:0]     upper_mask;
   logic [WIDTH-1:0]     req_upper;
   logic                 any_req;
   logic                 any_upper;
   logic [WIDTH_LOG-1:0] hit_idx;

   // Returns the index of the lowest set bit (0 when the vector is empty).
   function automatic logic [WIDTH_LOG-1:0] lowest_set(input logic [WIDTH-1:0] vec);
      lowest_set = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            lowest_set = WIDTH_LOG'(i);
         end
      end
   endfunction

   // Index increment is modulo WIDTH, not 2**WIDTH_LOG, so that a non-power-of-2 WIDTH
   // never produces an out-of-range index.
   always_comb begin
      bin_inc = (bin_q == LastIdx) ? '0 : bin_q + WIDTH_LOG'(1);
   end

   assign accept = (state_q == StHold) && rdy;

   // When a grant is accepted, the search starts just past that grant. In every other
   // case it starts at the priority pointer.
   assign search_base = accept ? bin_inc : ptr_q;

   // Circular search using a thermometer mask. The lowest request at or above the base
   // wins. If there is no such request, the search wraps and the lowest request overall
   // wins.
   always_comb begin
      upper_mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         upper_mask[i] = (WIDTH_LOG'(i) >= search_base);
      end
   end

   assign req_upper = req & upper_mask;
   assign any_upper = |req_upper;
   assign any_req   = |req;
   assign hit_idx   = any_upper ? lowest_set(req_upper) : lowest_set(req);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               bin_d   = hit_idx;
               state_d = StHold;
            end
         end
         StHold: begin
            // While rdy is low, the grant is frozen and req is ignored.
            if (rdy) begin
               ptr_d = bin_inc;
               if (any_req) begin
                  bin_d = hit_idx;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         bin_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         ptr_q   <= ptr_d;
      end
   end

   assign vld = (state_q == StHold);
   assign bin = bin_q;
   assign ptr = ptr_q;

   // A grant that is not accepted must stay valid and unchanged.
   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (vld && !rdy) |=> (vld && $stable(bin)));

   // Indices stay within 0..WIDTH-1.
   a_bin_range : assert property (@(posedge clk) disable iff (rst)
      (32'(bin) < WIDTH) && (32'(ptr) < WIDTH));

endmodule

// File: tb/tb_rr_bin_arb.sv
module tb_rr_bin_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req8 = '0;
   logic       rdy8 = 1'b0;
   logic       vld8;
   logic [2:0] bin8, ptr8;
   logic [4:0] req5 = '0;
   logic       rdy5 = 1'b0;
   logic       vld5;
   logic [2:0] bin5, ptr5;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state per instance: [0] = WIDTH 8, [1] = WIDTH 5
   int m_vld[2];
   int m_bin[2];
   int m_ptr[2];

   always #5 clk = ~clk;

   rr_bin_arb #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .req (req8),
      .vld (vld8),
      .rdy (rdy8),
      .bin (bin8),
      .ptr (ptr8)
   );

   rr_bin_arb #(.WIDTH(5)) u_dut5 (
      .clk (clk),
      .rst (rst),
      .req (req5),
      .vld (vld5),
      .rdy (rdy5),
      .bin (bin5),
      .ptr (ptr5)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model. It applies one rising edge, working directly from the arbitration rules.
   task automatic model_step(input int u, input int w, input logic [7:0] r, input logic rd);
      int  base;
      bit  hit;
      if (rst) begin
         m_vld[u] = 0;
         m_bin[u] = 0;
         m_ptr[u] = 0;
         return;
      end
      if (m_vld[u] == 1 && !rd) return;
      if (m_vld[u] == 1) m_ptr[u] = (m_bin[u] + 1) % w;
      base = m_ptr[u];
      hit  = 0;
      for (int k = 0; k < w; k++) begin
         int idx;
         idx = (base + k) % w;
         if (!hit && r[idx]) begin
            hit      = 1;
            m_bin[u] = idx;
         end
      end
      m_vld[u] = hit ? 1 : 0;
   endtask

   // One clock: the DUTs sample the inputs, the model advances, and the outputs are
   // compared #1 after the edge.
   task automatic tick();
      @(posedge clk);
      model_step(0, 8, req8, rdy8);
      model_step(1, 5, {3'b000, req5}, rdy5);
      #1;
      check_eq("vld8", {31'b0, vld8}, m_vld[0]);
      check_eq("bin8", {29'b0, bin8}, m_bin[0]);
      check_eq("ptr8", {29'b0, ptr8}, m_ptr[0]);
      check_eq("vld5", {31'b0, vld5}, m_vld[1]);
      check_eq("bin5", {29'b0, bin5}, m_bin[1]);
      check_eq("ptr5", {29'b0, ptr5}, m_ptr[1]);
   endtask

   initial begin
      m_vld = '{0, 0};
      m_bin = '{0, 0};
      m_ptr = '{0, 0};

      // Reset state
      rst = 1'b1;
      tick();
      check_eq("rst_vld", {31'b0, vld8}, 0);
      check_eq("rst_bin", {29'b0, bin8}, 0);
      check_eq("rst_ptr", {29'b0, ptr8}, 0);
      rst = 1'b0;

      // Single request
      req8 = 8'h00; rdy8 = 1'b1;
      tick();
      req8 = 8'b0001_0000;
      tick();
      check_eq("single_vld", {31'b0, vld8}, 1);
      check_eq("single_bin", {29'b0, bin8}, 4);
      req8 = 8'h00;
      tick();
      check_eq("single_ptr", {29'b0, ptr8}, 5);
      check_eq("single_idle", {31'b0, vld8}, 0);

      // Back-pressure: grant 2 pending, req changes while rdy is low
      req8 = 8'b0000_0100; rdy8 = 1'b0;
      tick();
      check_eq("bp_bin0", {29'b0, bin8}, 2);
      req8 = 8'b1000_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_vld", {31'b0, vld8}, 1);
         check_eq("bp_bin", {29'b0, bin8}, 2);
      end
      rdy8 = 1'b1;
      tick();
      check_eq("bp_next", {29'b0, bin8}, 7);
      check_eq("bp_ptr", {29'b0, ptr8}, 3);
      req8 = 8'h00;
      tick();
      check_eq("bp_wrap_ptr", {29'b0, ptr8}, 0);

      // Full rotation with every requester active
      req8 = 8'hFF; rdy8 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("rot_vld", {31'b0, vld8}, 1);
         check_eq("rot_bin", {29'b0, bin8}, i % 8);
      end
      req8 = 8'h00;
      tick();
      check_eq("rot_ptr", {29'b0, ptr8}, 2);

      // Wrap / skip: index 6 is not served twice in a row
      req8 = 8'b0010_0000;
      tick();
      req8 = 8'b0100_0001;
      tick();
      check_eq("wrap_ptr", {29'b0, ptr8}, 6);
      check_eq("wrap_b0", {29'b0, bin8}, 6);
      tick();
      check_eq("wrap_b1", {29'b0, bin8}, 0);
      tick();
      check_eq("wrap_b2", {29'b0, bin8}, 6);
      req8 = 8'h00;
      tick();

      // Reset while a grant is pending
      req8 = 8'h08; rdy8 = 1'b0;
      tick();
      check_eq("mid_bin", {29'b0, bin8}, 3);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_vld", {31'b0, vld8}, 0);
      check_eq("mid_rst_ptr", {29'b0, ptr8}, 0);
      rst = 1'b0;
      tick();
      check_eq("mid_re_vld", {31'b0, vld8}, 1);
      check_eq("mid_re_bin", {29'b0, bin8}, 3);

      // Random traffic on WIDTH 8, with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 49) == 0);
         req8 = (i % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom);
         rdy8 = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 1'b0; req8 = 8'h00; rdy8 = 1'b1;
      tick();

      // Non-power-of-2 width: requesters 0 and 4 alternate
      req5 = 5'b10001; rdy5 = 1'b1;
      tick();
      check_eq("np2_g0", {29'b0, bin5}, 0);
      tick();
      check_eq("np2_g1", {29'b0, bin5}, 4);
      tick();
      check_eq("np2_g2", {29'b0, bin5}, 0);
      check_eq("np2_ptr", {29'b0, ptr5}, 0);
      tick();
      check_eq("np2_g3", {29'b0, bin5}, 4);
      req5 = 5'b00000;
      tick();
      check_eq("np2_ptr_wrap", {29'b0, ptr5}, 0);

      // Random traffic on WIDTH 5
      for (int i = 0; i < 1000; i++) begin
         req5 = 5'($urandom);
         rdy5 = ($urandom_range(0, 3) != 0);
         tick();
         check_eq("np2_range", {31'b0, (bin5 < 3'd5)}, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
